// File: rtl/seq_gen_detect.sv
// Cyclic bit-stream generator feeding a KMP-style pattern detector.
// The detector has a Mealy hit (same cycle) and a Moore hit (next cycle),
// and a saturating hit counter. Overlap mode is selected per step at run time.
module seq_gen_detect #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               GEN_W   = 8,
  parameter logic [GEN_W-1:0] GEN_SEQ = 8'b1011_0110,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             nres,
  input  logic             en,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             gen_bit,
  output logic             OUTP_MEALY,
  output logic             OUTP_MOORE,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  // States 0..PAT_W-1 are matched-prefix lengths; PAT_W itself is S_FULL.
  localparam int SW = $clog2(PAT_W + 1);
  localparam int IW = $clog2(GEN_W);
  localparam logic [SW-1:0] S0     = '0;
  localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

  // Longest prefix of PATTERN that is a suffix of (prefix of length k, then b).
  // Returns PAT_W when the whole pattern completes, so S_FULL falls out naturally.
  function automatic int kmp_next(input int k, input int b);
    int best;
    int pos;
    int sb;
    bit ok;
    best = 0;
    for (int l = 1; l <= k + 1; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        pos = k + 1 - l + j;
        sb  = (pos == k) ? b : int'(PATTERN[PAT_W-1-pos]);
        if (sb != int'(PATTERN[PAT_W-1-j])) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Longest proper prefix of PATTERN that is also a suffix (KMP failure value).
  function automatic int kmp_border(input int n);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < n; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        if (PATTERN[n-1-j] != PATTERN[l-1-j]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  localparam logic [SW-1:0] BORDER_ST = SW'(kmp_border(PAT_W));

  logic [SW-1:0]    nxt_tab [PAT_W][2];
  logic [GEN_W-1:0] seq_rev;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    state_q, state_d;
  logic [SW-1:0]    eff_state;
  logic [SW-1:0]    step_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transition table is fixed at elaboration; no runtime table state.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_tab
      localparam logic [SW-1:0] N0 = SW'(kmp_next(gi, 0));
      localparam logic [SW-1:0] N1 = SW'(kmp_next(gi, 1));
      assign nxt_tab[gi][0] = N0;
      assign nxt_tab[gi][1] = N1;
    end
    // Bit-reverse the sequence so idx addresses it directly (MSB emitted first).
    for (gi = 0; gi < GEN_W; gi++) begin : g_rev
      assign seq_rev[gi] = GEN_SEQ[GEN_W-1-gi];
    end
  endgenerate

  assign gen_bit    = seq_rev[idx_q];
  assign OUTP_MOORE = (state_q == S_FULL);
  assign hit_cnt    = cnt_q;
  assign cnt_sat    = &cnt_q;

  // Generator index advances once per step and wraps at GEN_W-1.
  always_comb begin
    idx_d = idx_q;
    if (en) begin
      if (idx_q == IW'(GEN_W - 1)) idx_d = '0;
      else                         idx_d = idx_q + IW'(1);
    end
  end

  // Detector next state and Mealy hit; S_FULL exits via the border or S0.
  always_comb begin
    eff_state = state_q;
    if (state_q == S_FULL) eff_state = overlap ? BORDER_ST : S0;
    step_next  = nxt_tab[eff_state][gen_bit];
    state_d    = state_q;
    OUTP_MEALY = 1'b0;
    if (en) begin
      state_d    = step_next;
      OUTP_MEALY = (step_next == S_FULL);
    end
  end

  // Hit counter: clear wins over a hit; saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                     cnt_d = '0;
    else if (OUTP_MEALY && !cnt_sat) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      idx_q   <= '0;
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_gen_detect.sv
// Bench for seq_gen_detect: directed scenarios followed by random stepping,
// checked against a history-based model of the stream and pattern matches.
module tb_seq_gen_detect;

  logic       clk = 1'b0;
  logic       nres = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       gen_bit, mealy, moore, sat;
  logic [7:0] cnt;
  logic       gen_bit2, mealy2, moore2, sat2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  seq_gen_detect dut (
    .clk(clk), .nres(nres), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .gen_bit(gen_bit), .OUTP_MEALY(mealy), .OUTP_MOORE(moore),
    .hit_cnt(cnt), .cnt_sat(sat)
  );

  seq_gen_detect #(.CNT_W(2)) dut2 (
    .clk(clk), .nres(nres), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .gen_bit(gen_bit2), .OUTP_MEALY(mealy2), .OUTP_MOORE(moore2),
    .hit_cnt(cnt2), .cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  // Reference model: stream position, bits seen since the last match-window
  // clear, whether the last step was a hit, and the two counters.
  logic [7:0] gen_v = 8'b1011_0110;
  logic [3:0] pat_v = 4'b1011;
  int m_pos;
  bit m_hist[$];
  bit m_moore;
  int m_cnt1, m_cnt2;

  function automatic bit m_bit();
    return gen_v[7 - m_pos];
  endfunction

  // A hit is when the last four bits of the window (including this bit) spell
  // the pattern; non-overlap mode starts a fresh window after a hit.
  function automatic bit m_would_hit(input bit ov);
    bit h[$];
    bit ok;
    if (m_moore && !ov) h = {};
    else                h = m_hist;
    h.push_back(m_bit());
    if (h.size() < 4) return 1'b0;
    ok = 1'b1;
    for (int j = 0; j < 4; j++)
      if (h[h.size() - 4 + j] != pat_v[3 - j]) ok = 1'b0;
    return ok;
  endfunction

  function automatic void m_reset();
    m_pos = 0;
    m_hist.delete();
    m_moore = 1'b0;
    m_cnt1 = 0;
    m_cnt2 = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check before the rising edge,
  // then advance the model by what the rising edge will do.
  task automatic cyc(input bit e, input bit o, input bit c);
    bit exp_m;
    @(negedge clk);
    en = e; overlap = o; clr_cnt = c;
    #1;
    exp_m = e && m_would_hit(o);
    $display("cyc t=%0t en=%0b ov=%0b clr=%0b gen=%0b mealy=%0b moore=%0b cnt=%0d cnt2=%0d",
             $time, e, o, c, gen_bit, mealy, moore, cnt, cnt2);
    chk("gen_bit", gen_bit, m_bit());
    chk("moore", moore, m_moore);
    chk("mealy", mealy, exp_m);
    chk("hit_cnt", cnt, m_cnt1);
    chk("cnt_sat", sat, m_cnt1 == 255);
    chk("gen_bit2", gen_bit2, m_bit());
    chk("moore2", moore2, m_moore);
    chk("mealy2", mealy2, exp_m);
    chk("hit_cnt2", cnt2, m_cnt2);
    chk("cnt_sat2", sat2, m_cnt2 == 3);
    if (e) begin
      if (m_moore && !o) m_hist.delete();
      m_hist.push_back(m_bit());
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      m_moore = exp_m;
      m_pos = (m_pos + 1) % 8;
    end
    if (c) begin
      m_cnt1 = 0;
      m_cnt2 = 0;
    end else if (exp_m) begin
      if (m_cnt1 < 255) m_cnt1++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must react at once.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr_cnt = 1'b0;
    #2 nres = 1'b0;
    #1;
    chk("rst_gen_bit", gen_bit, 1);
    chk("rst_moore", moore, 0);
    chk("rst_mealy", mealy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_sat", sat, 0);
    chk("rst_cnt2", cnt2, 0);
    chk("rst_moore2", moore2, 0);
    m_reset();
    @(negedge clk);
    nres = 1'b1;
  endtask

  initial begin
    bit e, o, c;
    m_reset();

    // 1: reset, then idle; generator must stay frozen.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    chk("s1_gen_frozen", gen_bit, 1);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s1_gen_after_step", gen_bit, 0);

    // 2: overlapping detection over two generator periods.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s2_hits", cnt, 4);

    // 3: non-overlapping detection over two generator periods.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("s3_hits", cnt, 2);

    // 4: enable gaps around the completing step.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s4_moore_hold1", moore, 1);
    cyc(0, 1, 0);
    chk("s4_moore_hold2", moore, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s4_hits", cnt, 2);

    // 5: saturation of the narrow counter, then clear coincident with a hit.
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s5_sat_cnt2", cnt2, 3);
    chk("s5_sat_flag2", sat2, 1);
    begin : find_hit
      for (int i = 0; i < 16; i++) begin
        if (m_would_hit(1'b1)) begin
          cyc(1, 1, 1);
          disable find_hit;
        end
        cyc(1, 1, 0);
      end
    end
    cyc(0, 1, 0);
    chk("s5_clr_wins2", cnt2, 0);
    chk("s5_clr_wins1", cnt, 0);

    // 6: reset mid-match, then the first match must need a full pattern again.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s6_no_early_hit", cnt, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("s6_hit_at_4", cnt, 1);

    // Random stepping with overlap changes, clears and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      e = ($urandom_range(0, 3) != 0);
      o = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 40) == 0);
      cyc(e, o, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
